// File: rtl/pipeline_pkg.sv
// Shared constants and types for the MEM-stage store write buffer.
// Entries hold word addresses only; byte-offset bits are dropped on entry.
package pipeline_pkg;

    localparam int WORD_OFFSET_BITS = 2;
    localparam int SB_DEPTH         = 4;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-1:WORD_OFFSET_BITS] addr_word;
        logic [SB_DW-1:0]                data;
    } sb_entry_t;

    typedef logic [$clog2(SB_DEPTH):0] sb_count_t;

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match forwarding scan over the occupied store buffer entries.
// Walks oldest to youngest from rd_ptr so the last hit wins.
module sb_forward_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [PW-1:0]    rd_ptr,
    input  sb_count_t        count,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[WORD_OFFSET_BITS-1:0];

    // Occupied slots are rd_ptr .. rd_ptr+count-1 with natural wrap.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && (sb_count_t'(i) < count) &&
                (entries[PW'(rd_ptr + PW'(i))].addr_word == ld_addr[AW-1:WORD_OFFSET_BITS])) begin
                hit  = 1'b1;
                data = entries[PW'(rd_ptr + PW'(i))].data;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the MEM stage and slower data memory: accepts
// stores in one cycle, drains oldest first, forwards youngest data to loads.
module store_write_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     stall,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t       entries_q [DEPTH];
    sb_entry_t       entries_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    sb_count_t       count_q, count_d;
    logic            push;
    logic            pop;

    logic unused_st_offset;
    assign unused_st_offset = ^st_addr[WORD_OFFSET_BITS-1:0];

    // A full buffer refuses the store even if the head drains this cycle,
    // which keeps stall off the mem_ack timing path.
    assign full      = (count_q == sb_count_t'(DEPTH));
    assign empty     = (count_q == '0);
    assign stall     = st_valid & full;
    assign push      = st_valid & ~full;
    assign mem_req   = ~empty;
    assign pop       = mem_req & mem_ack;
    assign mem_addr  = {entries_q[rd_ptr_q].addr_word, {WORD_OFFSET_BITS{1'b0}}};
    assign mem_wdata = entries_q[rd_ptr_q].data;
    assign count     = count_q;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            entries_d[wr_ptr_q] = '{addr_word: st_addr[AW-1:WORD_OFFSET_BITS], data: st_data};
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry payloads need no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        if (init) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_forward (
        .entries  (entries_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .hit      (ld_hit),
        .data     (ld_data)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (init)
        count_q <= sb_count_t'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (init)
        !(push && !pop && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (init)
        !(pop && !push && empty));

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a scoreboard queue holds expected
// drain transactions, popped by a monitor on every accepted mem_req.
module tb_store_write_buffer;

    logic        clk;
    logic        init;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int          vectors;
    int          miscompares;
    int          model_count;
    logic [63:0] exp_q[$];

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .init      (init),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic ack, input logic ini);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        mem_ack  = ack;
        init     = ini;
    endtask

    task automatic setLoad(input logic lv, input logic [31:0] la);
        ld_valid = lv;
        ld_addr  = la;
        #1;
    endtask

    // Reference occupancy: full refuses a push even when the head drains.
    task automatic stepClock();
        logic accept;
        logic drain;
        if (init) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            accept = st_valid && (model_count < 4);
            drain  = mem_ack && (model_count > 0);
            if (accept) exp_q.push_back({st_addr & 32'hFFFF_FFFC, st_data});
            model_count = model_count + int'(accept) - int'(drain);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic storeCycle(input logic [31:0] sa, input logic [31:0] sd, input logic ack);
        applyStimulus(1'b1, sa, sd, ack, 1'b0);
        stepClock();
    endtask

    always @(negedge clk) begin
        if (!init && mem_req && mem_ack) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL drain_unexpected actual=%0h_%0h expected=no_request", mem_addr, mem_wdata);
            end else begin
                logic [63:0] exp_txn;
                exp_txn = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp_txn) begin
                    miscompares++;
                    $display("[TB] FAIL drain_order actual=%0h expected=%0h", {mem_addr, mem_wdata}, exp_txn);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_count = 0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        applyStimulus(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Reset held two cycles with a store pending.
        stepClock();
        stepClock();
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_empty", 64'(empty), 64'd1);
        checkOutput("reset_full", 64'(full), 64'd0);
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_ld_hit", 64'(ld_hit), 64'd0);
        checkOutput("reset_ld_data", 64'(ld_data), 64'd0);

        // Fill with memory stalled.
        storeCycle(32'h1001_0000, 32'h1111_0000, 1'b0);
        checkOutput("fill1_count", 64'(count), 64'd1);
        storeCycle(32'h1001_0004, 32'h2222_0001, 1'b0);
        storeCycle(32'h1001_0008, 32'h3333_0002, 1'b0);
        storeCycle(32'h1001_000C, 32'h4444_0003, 1'b0);
        checkOutput("fill_count", 64'(count), 64'd4);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_head_addr", 64'(mem_addr), 64'h1001_0000);
        checkOutput("fill_head_data", 64'(mem_wdata), 64'h1111_0000);

        applyStimulus(1'b1, 32'h1001_0010, 32'h5555_0004, 1'b0, 1'b0);
        #1;
        checkOutput("stall_when_full", 64'(stall), 64'd1);
        stepClock();
        checkOutput("count_held_full", 64'(count), 64'd4);
        checkOutput("head_stable_addr", 64'(mem_addr), 64'h1001_0000);
        applyStimulus(1'b1, 32'h1001_0010, 32'h5555_0004, 1'b1, 1'b0);
        #1;
        checkOutput("stall_despite_ack", 64'(stall), 64'd1);
        stepClock();
        checkOutput("after_first_ack_count", 64'(count), 64'd3);
        checkOutput("stall_cleared", 64'(stall), 64'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("drain_count2", 64'(count), 64'd2);
        stepClock();
        stepClock();
        checkOutput("drain_empty", 64'(empty), 64'd1);
        checkOutput("drain_mem_req", 64'(mem_req), 64'd0);

        // Youngest same-word store forwards.
        storeCycle(32'h1001_0008, 32'hAAAA_0001, 1'b0);
        storeCycle(32'h1001_000A, 32'hBBBB_0002, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        setLoad(1'b1, 32'h1001_0008);
        checkOutput("fwd_young_hit", 64'(ld_hit), 64'd1);
        checkOutput("fwd_young_data", 64'(ld_data), 64'hBBBB_0002);
        setLoad(1'b1, 32'h1001_0020);
        checkOutput("fwd_miss_hit", 64'(ld_hit), 64'd0);
        checkOutput("fwd_miss_data", 64'(ld_data), 64'd0);
        stepClock();
        applyStimulus(1'b1, 32'h1001_0020, 32'hCCCC_0003, 1'b0, 1'b0);
        #1;
        checkOutput("fwd_same_cycle_store", 64'(ld_hit), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        setLoad(1'b0, 32'h1001_0008);
        checkOutput("fwd_ld_invalid_hit", 64'(ld_hit), 64'd0);
        checkOutput("fwd_ld_invalid_data", 64'(ld_data), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("fwd_drain_empty", 64'(empty), 64'd1);

        // Move pointers to rd=3, wr=1 with two entries, then push+pop.
        storeCycle(32'h1001_0100, 32'h0000_A00A, 1'b0);
        storeCycle(32'h1001_0104, 32'h0000_B00B, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        storeCycle(32'h1001_0104, 32'h0000_C00C, 1'b0);
        checkOutput("wrap_count", 64'(count), 64'd2);
        checkOutput("wrap_head_data", 64'(mem_wdata), 64'h0000_B00B);
        setLoad(1'b1, 32'h1001_0104);
        checkOutput("wrap_fwd_hit", 64'(ld_hit), 64'd1);
        checkOutput("wrap_fwd_data", 64'(ld_data), 64'h0000_C00C);
        storeCycle(32'h1001_010C, 32'h0000_D00D, 1'b1);
        checkOutput("pushpop_count", 64'(count), 64'd2);
        checkOutput("pushpop_head_data", 64'(mem_wdata), 64'h0000_C00C);
        setLoad(1'b1, 32'h1001_010C);
        checkOutput("pushpop_fwd_data", 64'(ld_data), 64'h0000_D00D);
        setLoad(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("wrap_drain_empty", 64'(empty), 64'd1);

        // Reset while draining discards pending entries.
        storeCycle(32'h1001_0200, 32'h0000_E00E, 1'b0);
        storeCycle(32'h1001_0204, 32'h0000_F00F, 1'b0);
        storeCycle(32'h1001_0208, 32'h0000_1001, 1'b0);
        checkOutput("mid_count", 64'(count), 64'd3);
        checkOutput("mid_mem_req", 64'(mem_req), 64'd1);
        setLoad(1'b1, 32'h1001_0200);
        checkOutput("mid_fwd_hit", 64'(ld_hit), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        stepClock();
        checkOutput("init_count", 64'(count), 64'd0);
        checkOutput("init_mem_req", 64'(mem_req), 64'd0);
        checkOutput("init_fwd_miss", 64'(ld_hit), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("ack_when_empty_count", 64'(count), 64'd0);
        checkOutput("ack_when_empty_req", 64'(mem_req), 64'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        stepClock();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
